fetch_sequencer: RTL and testbench

- Sequences the instruction-fetch PC for the mig1 core.
- Issues one instruction-memory request at a time over a valid/ready handshake and buffers the returned instruction for decode.
- Applies jump/branch redirects from execute. In-flight fetches that become stale are squashed.
- Sits between the instruction memory port and the decode stage. It owns the architectural fetch PC.

---
 rtl/fetch_sequencer.sv | 121 ++++++++++++
 tb/tb_fetch_sequencer.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: owns the mig1 fetch PC and keeps one imem request in flight.
// The returned instruction is buffered for decode; redirects squash stale fetches.
module fetch_sequencer #(
    parameter int unsigned      WIDTH       = 32,
    parameter logic [WIDTH-1:0] RESET_ADDR  = '0,
    parameter int unsigned      INSTR_BYTES = WIDTH / 8
) (
    input  logic             clk,
    input  logic             reset,
    output logic             imem_req_valid,
    input  logic             imem_req_ready,
    output logic [WIDTH-1:0] imem_req_addr,
    input  logic             imem_rsp_valid,
    input  logic [WIDTH-1:0] imem_rsp_data,
    input  logic             redirect_valid,
    input  logic             redirect_is_jump,
    input  logic [WIDTH-1:0] redirect_offset,
    input  logic [WIDTH-1:0] redirect_pc,
    output logic             instr_valid,
    input  logic             instr_ready,
    output logic [WIDTH-1:0] instr,
    output logic [WIDTH-1:0] instr_pc,
    output logic [WIDTH-1:0] fetch_pc
);

    localparam logic [WIDTH-1:0] PC_INC = WIDTH'(INSTR_BYTES);

    typedef enum logic [1:0] {
        FETCH,
        WAIT,
        DROP,
        HOLD
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] w_pc_nxt;
    logic [WIDTH-1:0] r_instr;
    logic [WIDTH-1:0] r_instr_pc;
    logic [WIDTH-1:0] w_target;
    logic             w_capture;

    assign w_target = redirect_is_jump ? redirect_offset
                                       : redirect_pc + redirect_offset;

    // Redirect always retargets the PC; the state only decides what happens
    // to whatever is in flight or buffered.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_capture   = 1'b0;
        if (redirect_valid) begin
            w_pc_nxt = w_target;
        end
        unique case (r_state)
            FETCH: begin
                if (imem_req_ready) begin
                    w_state_nxt = redirect_valid ? DROP : WAIT;
                end
            end
            WAIT: begin
                if (redirect_valid) begin
                    w_state_nxt = imem_rsp_valid ? FETCH : DROP;
                end else if (imem_rsp_valid) begin
                    w_capture   = 1'b1;
                    w_pc_nxt    = r_pc + PC_INC;
                    w_state_nxt = HOLD;
                end
            end
            // A response here retires the stale request even if a new
            // redirect arrives in the same cycle.
            DROP: begin
                if (imem_rsp_valid) begin
                    w_state_nxt = FETCH;
                end
            end
            HOLD: begin
                if (redirect_valid || instr_ready) begin
                    w_state_nxt = FETCH;
                end
            end
            default: w_state_nxt = FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= FETCH;
            r_pc    <= RESET_ADDR;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_instr    <= '0;
            r_instr_pc <= '0;
        end else if (w_capture) begin
            r_instr    <= imem_rsp_data;
            r_instr_pc <= r_pc;
        end
    end

    assign imem_req_valid = (r_state == FETCH);
    assign instr_valid    = (r_state == HOLD);
    assign imem_req_addr  = r_pc;
    assign fetch_pc       = r_pc;
    assign instr          = r_instr;
    assign instr_pc       = r_instr_pc;

`ifndef SYNTHESIS
    a_no_stray_rsp: assert property (
        @(posedge clk) disable iff (reset)
        imem_rsp_valid |-> (r_state == WAIT || r_state == DROP)
    );
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: vector table, directed corner sequences,
// then random traffic against a transaction-level reference model.
module tb_fetch_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        req_ready, rsp_valid, rd_valid, rd_jump, instr_ready;
    logic [31:0] rsp_data, rd_off, rd_pc;
    logic        req_valid, ivalid;
    logic [31:0] req_addr, instr, ipc, fpc;

    logic        w_reset, w_ready, w_rsp_valid, w_ir;
    logic [31:0] w_rsp_data;
    logic        w_req_valid, w_ivalid;
    logic [31:0] w_addr, w_instr, w_ipc, w_fpc;

    int checks   = 0;
    int failures = 0;

    fetch_sequencer u_dut (
        .clk             (clk),
        .reset           (reset),
        .imem_req_valid  (req_valid),
        .imem_req_ready  (req_ready),
        .imem_req_addr   (req_addr),
        .imem_rsp_valid  (rsp_valid),
        .imem_rsp_data   (rsp_data),
        .redirect_valid  (rd_valid),
        .redirect_is_jump(rd_jump),
        .redirect_offset (rd_off),
        .redirect_pc     (rd_pc),
        .instr_valid     (ivalid),
        .instr_ready     (instr_ready),
        .instr           (instr),
        .instr_pc        (ipc),
        .fetch_pc        (fpc)
    );

    fetch_sequencer #(.RESET_ADDR(32'hFFFF_FFFC)) u_wrap (
        .clk             (clk),
        .reset           (w_reset),
        .imem_req_valid  (w_req_valid),
        .imem_req_ready  (w_ready),
        .imem_req_addr   (w_addr),
        .imem_rsp_valid  (w_rsp_valid),
        .imem_rsp_data   (w_rsp_data),
        .redirect_valid  (1'b0),
        .redirect_is_jump(1'b0),
        .redirect_offset (32'h0),
        .redirect_pc     (32'h0),
        .instr_valid     (w_ivalid),
        .instr_ready     (w_ir),
        .instr           (w_instr),
        .instr_pc        (w_ipc),
        .fetch_pc        (w_fpc)
    );

    typedef struct {
        logic        rdy;
        logic        rv;
        logic [31:0] rd;
        logic        ir;
        logic        e_rv;
        logic [31:0] e_addr;
        logic        e_iv;
        logic [31:0] e_instr;
        logic [31:0] e_ipc;
    } vec_t;

    vec_t tbl[10];

    // reference model: pending request, staleness, buffered instruction
    logic [31:0] m_pc, m_instr, m_ipc;
    bit          m_out, m_stale, m_held;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic chk_main(input string tag, input logic e_rv,
                            input logic [31:0] e_addr, input logic e_iv);
        chk({tag, ".req_valid"}, {31'b0, req_valid}, {31'b0, e_rv});
        chk({tag, ".req_addr"}, req_addr, e_addr);
        chk({tag, ".fetch_pc"}, fpc, e_addr);
        chk({tag, ".instr_valid"}, {31'b0, ivalid}, {31'b0, e_iv});
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        reset       = 1'b0;
        req_ready   = 1'b0;
        rsp_valid   = 1'b0;
        rsp_data    = '0;
        rd_valid    = 1'b0;
        rd_jump     = 1'b0;
        rd_off      = '0;
        rd_pc       = '0;
        instr_ready = 1'b0;
    endtask

    task automatic model_step();
        logic [31:0] tgt;
        if (reset) begin
            m_pc = 32'h0; m_out = 0; m_stale = 0; m_held = 0;
            m_instr = 32'h0; m_ipc = 32'h0;
        end else begin
            tgt = rd_jump ? rd_off : rd_pc + rd_off;
            if (m_held) begin
                if (rd_valid || instr_ready) m_held = 0;
            end else if (m_out) begin
                if (rsp_valid) begin
                    if (!rd_valid && !m_stale) begin
                        m_held  = 1;
                        m_instr = rsp_data;
                        m_ipc   = m_pc;
                        m_pc    = m_pc + 32'd4;
                    end
                    m_out   = 0;
                    m_stale = 0;
                end else if (rd_valid) begin
                    m_stale = 1;
                end
            end else if (req_ready) begin
                m_out   = 1;
                m_stale = rd_valid;
            end
            if (rd_valid) m_pc = tgt;
        end
    endtask

    initial begin
        tbl[0] = '{1, 0, 32'h0,  0, 1, 32'h0, 0, 32'h0,  32'h0};
        tbl[1] = '{0, 1, 32'hA0, 0, 0, 32'h0, 0, 32'h0,  32'h0};
        tbl[2] = '{0, 0, 32'h0,  1, 0, 32'h4, 1, 32'hA0, 32'h0};
        tbl[3] = '{1, 0, 32'h0,  0, 1, 32'h4, 0, 32'hA0, 32'h0};
        tbl[4] = '{0, 1, 32'hA1, 0, 0, 32'h4, 0, 32'hA0, 32'h0};
        tbl[5] = '{0, 0, 32'h0,  1, 0, 32'h8, 1, 32'hA1, 32'h4};
        tbl[6] = '{1, 0, 32'h0,  0, 1, 32'h8, 0, 32'hA1, 32'h4};
        tbl[7] = '{0, 1, 32'hA2, 0, 0, 32'h8, 0, 32'hA1, 32'h4};
        tbl[8] = '{0, 0, 32'h0,  1, 0, 32'hC, 1, 32'hA2, 32'h8};
        tbl[9] = '{0, 0, 32'h0,  0, 1, 32'hC, 0, 32'hA2, 32'h8};

        idle();
        reset       = 1'b1;
        w_reset     = 1'b1;
        w_ready     = 1'b0;
        w_rsp_valid = 1'b0;
        w_rsp_data  = '0;
        w_ir        = 1'b0;
        @(negedge clk);
        tick();
        reset = 1'b0;

        for (int i = 0; i < 10; i++) begin
            chk_main($sformatf("vec%0d", i), tbl[i].e_rv, tbl[i].e_addr,
                     tbl[i].e_iv);
            chk($sformatf("vec%0d.instr", i), instr, tbl[i].e_instr);
            chk($sformatf("vec%0d.instr_pc", i), ipc, tbl[i].e_ipc);
            idle();
            req_ready   = tbl[i].rdy;
            rsp_valid   = tbl[i].rv;
            rsp_data    = tbl[i].rd;
            instr_ready = tbl[i].ir;
            tick();
        end
        idle();

        // redirect while the request is not accepted
        rd_valid = 1'b1; rd_jump = 1'b1; rd_off = 32'h8;
        tick(); idle();
        chk_main("nacc_redir", 1'b1, 32'h8, 1'b0);
        req_ready = 1'b1;
        tick(); idle();
        chk_main("acc8", 1'b0, 32'h8, 1'b0);
        rd_valid = 1'b1; rd_jump = 1'b1; rd_off = 32'h100;
        tick(); idle();
        chk_main("wait_redir", 1'b0, 32'h100, 1'b0);
        tick();
        chk_main("drop_idle", 1'b0, 32'h100, 1'b0);
        rsp_valid = 1'b1; rsp_data = 32'hDEAD;
        tick(); idle();
        chk_main("drop_rsp", 1'b1, 32'h100, 1'b0);
        req_ready = 1'b1;
        tick(); idle();
        chk_main("acc100", 1'b0, 32'h100, 1'b0);
        rsp_valid = 1'b1; rsp_data = 32'hB0;
        tick(); idle();
        chk_main("hold100", 1'b0, 32'h104, 1'b1);
        chk("hold100.instr", instr, 32'hB0);
        chk("hold100.instr_pc", ipc, 32'h100);

        // branch redirect in HOLD with a same-cycle decode accept
        rd_valid = 1'b1; rd_jump = 1'b0;
        rd_pc = 32'h20; rd_off = 32'hFFFF_FFF0; instr_ready = 1'b1;
        tick(); idle();
        chk_main("hold_branch", 1'b1, 32'h10, 1'b0);
        req_ready = 1'b1;
        tick(); idle();
        rsp_valid = 1'b1; rsp_data = 32'hC0;
        tick(); idle();
        chk_main("hold10", 1'b0, 32'h14, 1'b1);
        chk("hold10.instr", instr, 32'hC0);
        chk("hold10.instr_pc", ipc, 32'h10);

        // reset while waiting on a response
        instr_ready = 1'b1;
        tick(); idle();
        req_ready = 1'b1;
        tick(); idle();
        chk_main("pre_rst_wait", 1'b0, 32'h14, 1'b0);
        reset = 1'b1; rd_valid = 1'b1; rd_jump = 1'b1; rd_off = 32'h300;
        tick(); idle();
        chk_main("mid_rst", 1'b1, 32'h0, 1'b0);
        chk("mid_rst.instr", instr, 32'h0);
        chk("mid_rst.instr_pc", ipc, 32'h0);

        // backpressure and PC wrap on the high-reset-address instance
        w_reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("bp%0d.req_valid", i), {31'b0, w_req_valid}, 32'h1);
            chk($sformatf("bp%0d.addr", i), w_addr, 32'hFFFF_FFFC);
            tick();
        end
        w_ready = 1'b1;
        tick();
        w_ready = 1'b0;
        w_rsp_valid = 1'b1; w_rsp_data = 32'hE0;
        tick();
        w_rsp_valid = 1'b0;
        chk("wrap.instr_valid", {31'b0, w_ivalid}, 32'h1);
        chk("wrap.instr", w_instr, 32'hE0);
        chk("wrap.instr_pc", w_ipc, 32'hFFFF_FFFC);
        w_ir = 1'b1;
        tick();
        w_ir = 1'b0;
        chk("wrap.next_valid", {31'b0, w_req_valid}, 32'h1);
        chk("wrap.next_addr", w_addr, 32'h0);

        // random traffic against the reference model
        idle();
        reset = 1'b1;
        model_step();
        tick();
        for (int c = 0; c < 3000; c++) begin
            chk_main($sformatf("rnd%0d", c), !m_held && !m_out, m_pc, m_held);
            chk($sformatf("rnd%0d.instr", c), instr, m_instr);
            chk($sformatf("rnd%0d.instr_pc", c), ipc, m_ipc);
            reset       = ($urandom_range(63) == 0);
            req_ready   = $urandom_range(1) != 0;
            rsp_valid   = m_out && ($urandom_range(1) != 0);
            rsp_data    = $urandom;
            rd_valid    = ($urandom_range(4) == 0);
            rd_jump     = $urandom_range(1) != 0;
            rd_off      = $urandom;
            rd_pc       = $urandom;
            instr_ready = $urandom_range(1) != 0;
            model_step();
            tick();
        end
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
